// File: rtl/dot_accumulator_if.sv
// dot_accumulator_if: sample input and frame-result output handshakes of the dot-product accumulator
interface dot_accumulator_if #(
   parameter int N     = 4,
   parameter int ACC_W = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [3*N:0]     in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_data;
   logic                    out_sat;
   modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sat);
   modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sat);
endinterface

// File: rtl/dot_accumulator.sv
// dot_accumulator: sums LEN signed samples per frame into a saturating accumulator
module dot_accumulator #(
   parameter int N     = 4,
   parameter int LEN   = 8,
   parameter int ACC_W = 16,
   parameter int CW    = $clog2(LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   dot_accumulator_if.slave     bus,
   output logic [CW-1:0]        count
);
   typedef enum logic {ACCUM, DONE} state_t;
   localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(2**(ACC_W-1) - 1);
   localparam logic signed [ACC_W:0] LO = -HI - 1;
   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] nxt;
   logic signed [ACC_W:0]   sum;
   logic signed [3*N:0]     sample;
   logic                    sat;
   logic                    clip;
   assign sample = bus.in_data;
   // one guard bit makes the overflow test exact before clamping
   assign sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(sample);
   always_comb begin
      clip = (sum > HI) || (sum < LO);
      nxt  = sum > HI ? HI[ACC_W-1:0] : sum < LO ? LO[ACC_W-1:0] : sum[ACC_W-1:0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst || clear) begin
         state <= ACCUM;
         acc   <= '0;
         sat   <= 1'b0;
         count <= '0;
      end else if (state == ACCUM && bus.in_valid) begin
         acc   <= nxt;
         sat   <= sat | clip;
         count <= count + 1'b1;
         if (count == CW'(LEN - 1)) state <= DONE;
      end else if (state == DONE && bus.out_ready) begin
         state <= ACCUM;
         acc   <= '0;
         sat   <= 1'b0;
         count <= '0;
      end
   end
   assign bus.in_ready  = state == ACCUM;
   assign bus.out_valid = state == DONE;
   assign bus.out_data  = acc;
   assign bus.out_sat   = sat;
endmodule

// File: tb/tb_dot_accumulator.sv
// tb_dot_accumulator: directed and random frames on LEN=8 and LEN=16 instances against a saturating-sum model
module tb_dot_accumulator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic              clr[2];
   logic              iv[2];
   logic              ordy[2];
   logic signed [12:0] idat[2];
   logic              ov[2];
   logic              ir[2];
   logic              os[2];
   logic signed [15:0] od[2];
   logic [4:0]        cnt[2];
   logic [3:0]        c0;
   logic [4:0]        c1;
   dot_accumulator_if #(.N(4), .ACC_W(16)) b0();
   dot_accumulator_if #(.N(4), .ACC_W(16)) b1();
   dot_accumulator #(.N(4), .LEN(8), .ACC_W(16)) u0(.clk(clk), .rst(rst), .clear(clr[0]), .bus(b0), .count(c0));
   dot_accumulator #(.N(4), .LEN(16), .ACC_W(16)) u1(.clk(clk), .rst(rst), .clear(clr[1]), .bus(b1), .count(c1));
   assign b0.in_valid = iv[0];
   assign b0.in_data = idat[0];
   assign b0.out_ready = ordy[0];
   assign b1.in_valid = iv[1];
   assign b1.in_data = idat[1];
   assign b1.out_ready = ordy[1];
   assign ov[0] = b0.out_valid;
   assign ov[1] = b1.out_valid;
   assign ir[0] = b0.in_ready;
   assign ir[1] = b1.in_ready;
   assign os[0] = b0.out_sat;
   assign os[1] = b1.out_sat;
   assign od[0] = b0.out_data;
   assign od[1] = b1.out_data;
   assign cnt[0] = {1'b0, c0};
   assign cnt[1] = c1;
   int macc[2];
   int mcnt[2];
   bit msat[2];
   int lens[2] = '{8, 16};
   int vecs = 0;
   int errs = 0;
   task automatic chk(string tag, int s, logic signed [31:0] o, logic signed [31:0] e);
      vecs++;
      assert (o === e) else begin
         errs++;
         $error("FAIL %s[len%0d]: got %0d want %0d", tag, lens[s], o, e);
      end
   endtask
   task automatic look(int s);
      bit d = mcnt[s] == lens[s];
      chk("out_valid", s, ov[s], d);
      chk("in_ready", s, ir[s], !d);
      chk("count", s, cnt[s], mcnt[s]);
      if (d) begin
         chk("out_data", s, od[s], macc[s]);
         chk("out_sat", s, os[s], msat[s]);
      end
   endtask
   task automatic mreset(int s);
      macc[s] = 0;
      mcnt[s] = 0;
      msat[s] = 0;
   endtask
   task automatic accept(int s, int x);
      int t = macc[s] + x;
      if (t > 32767) begin
         t = 32767;
         msat[s] = 1;
      end else if (t < -32768) begin
         t = -32768;
         msat[s] = 1;
      end
      macc[s] = t;
      mcnt[s]++;
   endtask
   task automatic send(int s, int x);
      iv[s] = 1'b1;
      idat[s] = 13'(x);
      @(negedge clk);
      accept(s, x);
      iv[s] = 1'b0;
      look(s);
   endtask
   task automatic take(int s);
      ordy[s] = 1'b1;
      @(negedge clk);
      ordy[s] = 1'b0;
      mreset(s);
      look(s);
   endtask
   task automatic stall(int s, int k);
      repeat (k) begin
         iv[s] = 1'b1;
         idat[s] = 13'($urandom);
         ordy[s] = 1'b0;
         @(negedge clk);
         look(s);
      end
      iv[s] = 1'b0;
   endtask
   int basic[8] = '{5, -3, 192, -168, 0, 7, -1, 64};
   initial begin
      for (int s = 0; s < 2; s++) begin
         clr[s] = 1'b0;
         iv[s] = 1'b0;
         ordy[s] = 1'b0;
         idat[s] = '0;
         mreset(s);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         look(s);
         chk("reset_out_data", s, od[s], 0);
         chk("reset_out_sat", s, os[s], 0);
      end
      @(negedge clk);
      // asynchronous reset in the middle of a frame
      repeat (3) send(0, 10);
      #2 rst = 1'b1;
      #1;
      chk("async_count", 0, cnt[0], 0);
      chk("async_out_valid", 0, ov[0], 0);
      chk("async_out_data", 0, od[0], 0);
      mreset(0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      look(0);
      repeat (8) send(0, 1);
      chk("after_reset_sum", 0, od[0], 8);
      take(0);
      for (int i = 0; i < 8; i++) send(0, basic[i]);
      chk("basic_sum", 0, od[0], 96);
      chk("basic_sat", 0, os[0], 0);
      stall(0, 5);
      take(0);
      repeat (16) send(1, 4095);
      chk("pos_sat_data", 1, od[1], 32767);
      chk("pos_sat_flag", 1, os[1], 1);
      take(1);
      repeat (9) send(1, -4096);
      repeat (7) send(1, 4095);
      chk("neg_sat_data", 1, od[1], -4103);
      chk("neg_sat_flag", 1, os[1], 1);
      take(1);
      // clear beats an accept in ACCUM
      repeat (2) send(0, 3);
      iv[0] = 1'b1;
      idat[0] = 13'(5);
      clr[0] = 1'b1;
      @(negedge clk);
      clr[0] = 1'b0;
      iv[0] = 1'b0;
      mreset(0);
      look(0);
      // clear beats a completing output handshake in DONE
      repeat (8) send(0, 2);
      ordy[0] = 1'b1;
      clr[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;
      clr[0] = 1'b0;
      mreset(0);
      look(0);
      for (int i = 0; i < 8; i++) send(0, basic[i]);
      chk("post_clear_sum", 0, od[0], 96);
      take(0);
      for (int it = 0; it < 40; it++) begin
         int s = int'($urandom_range(0, 1));
         bit big = $urandom_range(0, 1) == 1;
         bit pos = $urandom_range(0, 1) == 1;
         for (int k = 0; k < lens[s]; k++) begin
            repeat ($urandom_range(0, 2)) begin
               idat[s] = 13'($urandom);
               @(negedge clk);
               look(s);
            end
            if (big) send(s, pos ? int'($urandom_range(3000, 4095)) : -int'($urandom_range(3000, 4096)));
            else send(s, int'($urandom_range(0, 8191)) - 4096);
         end
         stall(s, int'($urandom_range(0, 3)));
         take(s);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/dot_accumulator.md
# dot_accumulator

Sequential accumulator directly downstream of the signed Booth vector-multiply stage. It consumes a stream of (3N+1)-bit signed dot-product results over a valid/ready handshake. It sums LEN consecutive results into a saturating ACC_W-bit signed accumulator and presents the total on a valid/ready output port. Typical use is building long dot products (vector length 3·LEN) out of the 3-element multiply stage.

## Interface
- N, 4, operand width of the upstream multiply stage; input sample width is 3N+1.
- LEN, 8, samples per accumulation frame; ≥ 1.
- ACC_W, 16, accumulator/output width; must be ≥ 3N+1.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- clear  input  1  synchronous abort: discard the frame in progress.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  3N+1  signed sample, the upstream Z.
- out_valid  output  1  out_data/out_sat hold a finished frame.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_W  signed saturated frame sum.
- out_sat  output  1  saturation occurred at least once in this frame.
- count  output  ceil(log2(LEN+1))  samples accepted in the current frame.

## Operation
- States: ACCUM and DONE.
- Reset (rst=1, any time, asynchronous):
  - state=ACCUM, acc=0, count=0, sat flag=0.
  - out_valid=0, out_data=0, out_sat=0, in_ready=1 as soon as rst deasserts.
  - Reset mid-frame discards all partial data.
- ACCUM:
  - in_ready=1, out_valid=0.
  - A sample is accepted when in_valid&&in_ready at a clock edge.
  - On accept: in_data is sign-extended to ACC_W+1 and added to acc, also sign-extended to ACC_W+1.
  - If the result exceeds 2^(ACC_W-1)-1, acc clamps to that maximum. If it is below -2^(ACC_W-1), acc clamps to that minimum. Either clamp sets the sticky sat flag.
  - Clamping applies per sample; later samples of opposite sign move acc off the rail.
  - count increments on each accept.
  - On the accept that makes count reach LEN, go to DONE next cycle.
- DONE:
  - out_valid=1, out_data=final acc, out_sat=sat flag, count=LEN.
  - in_ready=0, so upstream is stalled (backpressure).
  - out_data and out_sat stay stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: acc=0, count=0, sat=0, return to ACCUM. in_ready=1 the following cycle; there is no same-cycle pass-through.
- clear (sync; priority over every handshake, below rst):
  - Next state ACCUM, acc=0, count=0, sat=0, out_valid=0.
  - An input accepted in the same cycle as clear is dropped.
  - A result pending in DONE is discarded, even if out_ready=1 that cycle.
- Arithmetic is two's complement throughout. out_data reflects the saturated value and is never wrapped.
- LEN=1: every accepted sample produces one result, passed through with sign extension.

## Timing
- Throughput: one sample per cycle in ACCUM.
- Result latency: out_valid rises the cycle after the LEN-th accept.
- Frame period with out_ready held high: LEN+1 cycles, because one DONE cycle is inserted per frame.
- All outputs are registered; no combinational path from inputs to outputs. in_ready is decoded from the state register only.
- in_valid/in_data may change freely while in_ready=0; they are ignored.

## Test plan
- Reset mid-frame: accept 3 samples of 10, assert rst asynchronously between edges.
  - Outputs go to 0 (count=0, out_valid=0) immediately.
  - The next full frame of 8×1 gives out_data=8.
- Basic frame (defaults): inputs 5, -3, 192, -168, 0, 7, -1, 64.
  - out_valid on the cycle after the 8th accept, out_data=96, out_sat=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_data/out_sat stable, in_ready=0, and no new sample accepted while in_valid=1.
  - When out_ready=1: handshake completes, in_ready=1 the next cycle.
- Positive saturation (LEN=16): sixteen samples of 4095.
  - acc=32760 after 8 samples, then clamps at 9.
  - out_data=32767, out_sat=1.
- Negative saturation and recovery (LEN=16): nine samples of -4096, then seven of +4095.
  - acc is -32768 after 8 samples with no saturation; the 9th clamps and sets sat.
  - Final out_data = -32768 + 7·4095 = -4103, out_sat=1.
- clear collision: assert clear together with in_valid in ACCUM, and separately with out_ready in DONE.
  - The sample is dropped and count=0.
  - The pending result is discarded, out_valid=0 next cycle, and the following frame sums from 0.
